// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder serving a small 16-bit register file.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept a frame after a single preamble 1 bit.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR  = 5'd1,
  parameter int          REG_COUNT = 8,
  parameter logic [15:0] BMCR_RST  = 16'h3100,
  parameter logic [15:0] BMSR_VAL  = 16'h786D,
  parameter logic [15:0] PHY_ID1   = 16'h0022,
  parameter logic [15:0] PHY_ID2   = 16'h1550,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  output logic        reg_wr_o,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_MIN = 6'd1;
`else
  localparam logic [5:0] PRE_MIN = 6'd32;
`endif
  localparam logic [5:0]    REG_LIM = 6'(REG_COUNT);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_mdc_sync, r_mdio_sync;
  logic           r_mdc_d;
  logic           w_bit, w_din, w_timeout, w_phy_hit, w_wr_hit;
  logic [5:0]     r_pre_cnt;
  logic [4:0]     r_bit_cnt;
  logic           r_op_bit0, r_op_rd;
  logic [4:0]     r_phyad, r_regad, w_regad_full;
  logic [15:0]    r_shift, w_rd_word;
  logic [TW-1:0]  r_to_cnt;
  logic           r_wr_pend;
  logic           r_mdio_o, r_mdio_oe, r_wr;
  logic [4:0]     r_addr;
  logic [15:0]    r_wdata;
  logic [15:0]    r_regs [32];

  assign w_bit        = r_mdc_sync[1] & ~r_mdc_d;
  assign w_din        = r_mdio_sync[1];
  assign w_phy_hit    = (r_phyad == PHY_ADDR);
  assign w_regad_full = {r_regad[3:0], w_din};
  assign w_timeout    = (r_state != S_IDLE) && !w_bit && (r_to_cnt == TO_LAST);
  assign w_wr_hit     = (r_regad == 5'd0) ||
                        ((r_regad >= 5'd4) && ({1'b0, r_regad} < REG_LIM));

  assign mdio_o      = r_mdio_o;
  assign mdio_oe_o   = r_mdio_oe;
  assign reg_wr_o    = r_wr;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;

  // Pin synchronizers and MDC edge history
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b11;
      r_mdc_d     <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[0], mdc_i};
      r_mdio_sync <= {r_mdio_sync[0], mdio_i};
      r_mdc_d     <= r_mdc_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame decode next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_bit) begin
      case (r_state)
        S_IDLE: begin
          if (!w_din && (r_pre_cnt >= PRE_MIN)) w_state_nxt = S_ST;
          else                                  w_state_nxt = S_IDLE;
        end
        S_ST:   w_state_nxt = w_din ? S_OP : S_IDLE;
        S_OP: begin
          if (!r_bit_cnt[0])            w_state_nxt = S_OP;
          else if (r_op_bit0 != w_din)  w_state_nxt = S_PHYAD;
          else                          w_state_nxt = S_IDLE;
        end
        S_PHYAD: w_state_nxt = (r_bit_cnt == 5'd4) ? S_REGAD : S_PHYAD;
        S_REGAD: begin
          if (r_bit_cnt != 5'd4) w_state_nxt = S_REGAD;
          else if (w_phy_hit)    w_state_nxt = S_TA;
          else                   w_state_nxt = S_SKIP;
        end
        // Reads just wait out TA; writes must see exactly 1 then 0
        S_TA: begin
          if (r_op_rd)            w_state_nxt = r_bit_cnt[0] ? S_DATA : S_TA;
          else if (r_bit_cnt[0])  w_state_nxt = w_din ? S_IDLE : S_DATA;
          else                    w_state_nxt = w_din ? S_TA : S_IDLE;
        end
        S_DATA:  w_state_nxt = (r_bit_cnt == 5'd15) ? S_IDLE : S_DATA;
        S_SKIP:  w_state_nxt = (r_bit_cnt == 5'd17) ? S_IDLE : S_SKIP;
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Read-word mux over the register file
  always_comb begin
    w_rd_word = 16'h0000;
    case (w_regad_full)
      5'd1:    w_rd_word = BMSR_VAL;
      5'd2:    w_rd_word = PHY_ID1;
      5'd3:    w_rd_word = PHY_ID2;
      default: begin
        if ({1'b0, w_regad_full} < REG_LIM) w_rd_word = r_regs[w_regad_full];
        else                                w_rd_word = 16'h0000;
      end
    endcase
  end

  // MDC watchdog, counted only inside a frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Per-bit datapath: field capture, read shift-out and pin drive
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 5'd0;
      r_op_bit0 <= 1'b0;
      r_op_rd   <= 1'b0;
      r_phyad   <= 5'd0;
      r_regad   <= 5'd0;
      r_shift   <= 16'h0000;
      r_wr_pend <= 1'b0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
      if (w_timeout) begin
        r_pre_cnt <= 6'd0;
        r_bit_cnt <= 5'd0;
        r_mdio_oe <= 1'b0;
        r_mdio_o  <= 1'b1;
      end else if (w_bit) begin
        r_bit_cnt <= (w_state_nxt != r_state) ? 5'd0 : r_bit_cnt + 5'd1;
        case (r_state)
          S_IDLE: begin
            if (!w_din)                  r_pre_cnt <= 6'd0;
            else if (r_pre_cnt != 6'd32) r_pre_cnt <= r_pre_cnt + 6'd1;
          end
          S_OP: begin
            if (r_bit_cnt[0]) r_op_rd   <= r_op_bit0;
            else              r_op_bit0 <= w_din;
          end
          S_PHYAD: r_phyad <= {r_phyad[3:0], w_din};
          // Read word is frozen here so a later write cannot leak into it
          S_REGAD: begin
            r_regad <= w_regad_full;
            if (r_bit_cnt == 5'd4) r_shift <= w_rd_word;
          end
          S_TA: begin
            if (r_op_rd && !r_bit_cnt[0]) begin
              r_mdio_oe <= 1'b1;
              r_mdio_o  <= 1'b0;
            end else if (r_op_rd) begin
              r_mdio_o <= r_shift[15];
              r_shift  <= {r_shift[14:0], 1'b0};
            end
          end
          S_DATA: begin
            if (r_op_rd && (r_bit_cnt == 5'd15)) begin
              r_mdio_oe <= 1'b0;
              r_mdio_o  <= 1'b1;
            end else if (r_op_rd) begin
              r_mdio_o <= r_shift[15];
              r_shift  <= {r_shift[14:0], 1'b0};
            end else begin
              r_shift   <= {r_shift[14:0], w_din};
              r_wr_pend <= (r_bit_cnt == 5'd15);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Write commit: register file, last-write outputs and strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr    <= 1'b0;
      r_addr  <= 5'd0;
      r_wdata <= 16'h0000;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 0) ? BMCR_RST : 16'h0000;
      end
    end else begin
      r_wr <= 1'b0;
      if (r_wr_pend && w_wr_hit) begin
        r_wr    <= 1'b1;
        r_addr  <= r_regad;
        r_wdata <= r_shift;
        if (r_regad == 5'd0) r_regs[0]       <= {1'b0, r_shift[14:0]};
        else                 r_regs[r_regad] <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: a bit-banged MDIO master issues frames and
// queues expected responses; independent monitors check read words and write strobes.
module tb_mdio_responder;

  localparam int TIMEOUT = 1024;

  typedef struct {
    int          nb;
    logic [16:0] bits;
    bit          to;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_exp_t;

  logic        clk, rst_n, mdc, m_out, m_oe;
  logic        mdio_o, mdio_oe_o, reg_wr_o;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  wire         pin;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];
  int      n_total = 0;
  int      n_pass  = 0;

  assign pin = mdio_oe_o ? mdio_o : (m_oe ? m_out : 1'b1);

  mdio_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .mdc_i       (mdc),
    .mdio_i      (pin),
    .mdio_o      (mdio_o),
    .mdio_oe_o   (mdio_oe_o),
    .reg_wr_o    (reg_wr_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic send_bit(input logic b, input logic drv);
    @(negedge clk);
    mdc = 1'b0; m_out = b; m_oe = drv;
    repeat (7) @(negedge clk);
    @(negedge clk);
    mdc = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  // tail = number of released bits clocked after REGAD on a read (18 = full frame)
  task automatic frame(input int pre, input bit rd, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int tail);
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(rd, 1'b1);
    send_bit(!rd, 1'b1);
    for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b1);
    for (int i = 4; i >= 0; i--) send_bit(ra[i], 1'b1);
    if (rd) begin
      for (int i = 0; i < tail; i++) send_bit(1'b1, 1'b0);
    end else begin
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      for (int i = 15; i >= 0; i--) send_bit(wd[i], 1'b1);
    end
    m_oe = 1'b0;
  endtask

  task automatic exp_read(input logic [15:0] d);
    exp_rd.push_back('{nb: 17, bits: {1'b0, d}, to: 1'b0});
  endtask

  task automatic exp_write(input logic [4:0] a, input logic [15:0] d);
    exp_wr.push_back('{a: a, d: d});
  endtask

  // Read monitor: shifts in the pin at each MDC rise while the DUT drives it
  initial begin : rd_monitor
    logic        mdc_q, oe_q, ok;
    logic [16:0] acc;
    int          nb, cyc, rise_cyc;
    rd_exp_t     e;
    mdc_q = 1'b0; oe_q = 1'b0; acc = '0; nb = 0; cyc = 0; rise_cyc = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (mdio_oe_o && !oe_q) begin
        acc = '0;
        nb  = 0;
      end
      if (mdc && !mdc_q) begin
        rise_cyc = cyc;
        if (mdio_oe_o) begin
          acc = {acc[15:0], pin};
          nb++;
        end
      end
      if (!mdio_oe_o && oe_q) begin
        if (exp_rd.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: got %0d bits %h, expected no response", nb, acc);
        end else begin
          e = exp_rd.pop_front();
          check("rd_nbits", nb, e.nb);
          check("rd_data", {15'd0, acc}, {15'd0, e.bits});
          if (e.to) begin
            ok = ((cyc - rise_cyc) >= TIMEOUT + 2) && ((cyc - rise_cyc) <= TIMEOUT + 4);
            if (!ok) $display("timeout release after %0d cycles", cyc - rise_cyc);
            check("rd_timeout_delay", {31'd0, ok}, 32'd1);
          end
        end
      end
      mdc_q = mdc;
      oe_q  = mdio_oe_o;
    end
  end

  // Write monitor: every strobe must match the next queued write
  initial begin : wr_monitor
    wr_exp_t w;
    forever begin
      @(negedge clk); #2;
      if (reg_wr_o === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_total++;
          $display("FAIL wr_unexpected: got addr %h data %h, expected no write", reg_addr_o, reg_wdata_o);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", {27'd0, reg_addr_o}, {27'd0, w.a});
          check("wr_data", {16'd0, reg_wdata_o}, {16'd0, w.d});
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; mdc = 1'b0; m_out = 1'b1; m_oe = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_oe", {31'd0, mdio_oe_o}, 32'd0);
    check("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    check("rst_wr", {31'd0, reg_wr_o}, 32'd0);
    check("rst_addr", {27'd0, reg_addr_o}, 32'd0);
    check("rst_wdata", {16'd0, reg_wdata_o}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    exp_read(16'h0022);                 frame(32, 1'b1, 5'd1, 5'd2, 16'h0, 18);
    exp_read(16'h3100);                 frame(32, 1'b1, 5'd1, 5'd0, 16'h0, 18);
    exp_write(5'd4, 16'hA5C3);          frame(32, 1'b0, 5'd1, 5'd4, 16'hA5C3, 0);
    exp_read(16'hA5C3);                 frame(32, 1'b1, 5'd1, 5'd4, 16'h0, 18);
    exp_write(5'd0, 16'h8000);          frame(32, 1'b0, 5'd1, 5'd0, 16'h8000, 0);
    exp_read(16'h0000);                 frame(32, 1'b1, 5'd1, 5'd0, 16'h0, 18);
    // Writes to constant and unimplemented registers are dropped silently
    frame(32, 1'b0, 5'd1, 5'd2, 16'hFFFF, 0);
    frame(32, 1'b0, 5'd1, 5'd9, 16'h1234, 0);
    exp_read(16'h0022);                 frame(32, 1'b1, 5'd1, 5'd2, 16'h0, 18);
    exp_read(16'h0000);                 frame(32, 1'b1, 5'd1, 5'd9, 16'h0, 18);
    frame(32, 1'b1, 5'd3, 5'd1, 16'h0, 18);
    exp_read(16'h786D);                 frame(32, 1'b1, 5'd1, 5'd1, 16'h0, 18);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp_read(16'h1550);
`endif
    frame(31, 1'b1, 5'd1, 5'd3, 16'h0, 18);

    // MDC stops after D11 of reg 1 (786D): TA 0 then 0,1,1,1,1
    exp_rd.push_back('{nb: 6, bits: 17'h0000F, to: 1'b1});
    frame(32, 1'b1, 5'd1, 5'd1, 16'h0, 7);
    repeat (TIMEOUT + 64) @(negedge clk);
    exp_read(16'h1550);                 frame(32, 1'b1, 5'd1, 5'd3, 16'h0, 18);

    // Reset during the read drive of reg 3: TA 0 then D15..D13 = 000
    exp_rd.push_back('{nb: 4, bits: 17'h00000, to: 1'b0});
    frame(32, 1'b1, 5'd1, 5'd3, 16'h0, 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_oe", {31'd0, mdio_oe_o}, 32'd0);
    check("midrst_mdio_o", {31'd0, mdio_o}, 32'd1);
    check("midrst_wdata", {16'd0, reg_wdata_o}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_read(16'h0000);                 frame(32, 1'b1, 5'd1, 5'd4, 16'h0, 18);
    exp_read(16'h3100);                 frame(32, 1'b1, 5'd1, 5'd0, 16'h0, 18);

    repeat (40) @(negedge clk);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
